spi_master_driver: RTL

//  Drives the SPI master side of the lab SPI link: generates CS, SCLK, MOSI
//  for the peripheral and captures MISO, one WIDTH-bit frame per start.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_halfperiod_timer.sv | 31 +++
 rtl/spi_master_driver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master driver: state encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  localparam int SPI_WIDTH      = 8;
  localparam int SPI_HALFPERIOD = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Half-period timer: counts 0..HALFPERIOD-1 and flags the last cycle of each half-period.
// Latency: tick asserts HALFPERIOD-1 cycles after clear is released, then every HALFPERIOD cycles.
// Backpressure: none; clear holds the count at zero and suppresses tick.
module spi_halfperiod_timer #(
  parameter int HALFPERIOD = 8,
  parameter int CNTW       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [CNTW-1:0] LAST = CNTW'(HALFPERIOD - 1);

  logic [CNTW-1:0] cnt;

  // Free-running half-period count, restarted by clear and wrapped on the last cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNTW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/spi_master_driver.sv
// SPI mode-0 master: sends one MSB-first WIDTH-bit frame per accepted start and captures MISO.
// Latency: CS low (2*WIDTH+1)*HALFPERIOD cycles after accept; done pulses as CS rises.
// Backpressure: start is accepted only in IDLE (busy low); starts while busy are dropped.
module spi_master_driver
  import spi_pkg::*;
#(
  parameter int WIDTH      = SPI_WIDTH,
  parameter int HALFPERIOD = SPI_HALFPERIOD,
  parameter int CNTW       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             cs,
  output logic             sclk,
  output logic             mosi
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  spi_state_t state, state_nxt;

  logic [WIDTH-1:0] tx_sr, tx_sr_nxt;
  logic [WIDTH-1:0] rx_sr, rx_sr_nxt;
  logic [WIDTH-1:0] rx_data_nxt;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic             cs_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic             gap_wrap, gap_wrap_nxt;
  logic             timer_clear, tick;
  logic             miso_meta, miso_sync;

  spi_halfperiod_timer #(
    .HALFPERIOD (HALFPERIOD),
    .CNTW       (CNTW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous MISO line.
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode; every pin is registered from these values.
  always_comb begin
    state_nxt    = state;
    cs_nxt       = cs;
    sclk_nxt     = sclk;
    mosi_nxt     = mosi;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rx_data_nxt  = rx_data;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    bit_cnt_nxt  = bit_cnt;
    gap_wrap_nxt = gap_wrap;
    timer_clear  = 1'b0;
    case (state)
      S_IDLE: begin
        // Timer held at zero so SETUP starts a full half-period.
        timer_clear = 1'b1;
        if (start) begin
          tx_sr_nxt   = tx_data;
          mosi_nxt    = tx_data[WIDTH-1];
          cs_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (tick) begin
          sclk_nxt  = 1'b1;
          state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        // Sample at the end of the high phase so the synchronizer has settled.
        if (tick) begin
          rx_sr_nxt = {rx_sr[WIDTH-2:0], miso_sync};
          sclk_nxt  = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_HOLD;
          end else begin
            tx_sr_nxt   = {tx_sr[WIDTH-2:0], 1'b0};
            mosi_nxt    = tx_sr[WIDTH-2];
            bit_cnt_nxt = bit_cnt + BCW'(1);
            state_nxt   = S_LOW;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          cs_nxt       = 1'b1;
          mosi_nxt     = 1'b0;
          rx_data_nxt  = rx_sr;
          done_nxt     = 1'b1;
          gap_wrap_nxt = 1'b0;
          state_nxt    = S_GAP;
        end
      end
      S_GAP: begin
        // One extra cycle after the gap half-period before busy drops.
        if (gap_wrap) begin
          busy_nxt     = 1'b0;
          gap_wrap_nxt = 1'b0;
          state_nxt    = S_IDLE;
        end else if (tick) begin
          gap_wrap_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output pins and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      gap_wrap <= 1'b0;
    end else begin
      cs       <= cs_nxt;
      sclk     <= sclk_nxt;
      mosi     <= mosi_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rx_data  <= rx_data_nxt;
      tx_sr    <= tx_sr_nxt;
      rx_sr    <= rx_sr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_wrap <= gap_wrap_nxt;
    end
  end

endmodule
